// File: rtl/mips_alu_pkg.sv
// Shared encodings for the sequential MIPS-style ALU: operation codes and FSM states.
// Also holds the decode helper that separates iterative ops from single-cycle ones.
package mips_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_SLL   = 4'b0010,
        OP_NOR   = 4'b0011,
        OP_AND   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_OR    = 4'b0110,
        OP_SRL   = 4'b0111,
        OP_SLTU  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIVU  = 4'b1010
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // MULTU and DIVU run through the bit-serial iterator; everything else is one cycle.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// Bit-serial unsigned multiplier (shift-add) and restoring divider sharing one datapath.
// hi/lo present the post-step values so the owner can capture them on the final step.
module mips_muldiv_iter
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [SHW:0] LAST_CNT = (SHW+1)'(WIDTH - 1);

    logic             busy;
    logic             div_mode;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] aux_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // Multiply: hi accumulates, lo holds the multiplier and fills with product bits.
    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, aux_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, aux_q};
        step_hi   = hi_q;
        step_lo   = lo_q;
        if (div_mode) begin
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done = busy && (cnt == LAST_CNT);
    assign hi   = step_hi;
    assign lo   = step_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            aux_q    <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= a;
            aux_q    <= b;
        end else if (busy) begin
            hi_q <= step_hi;
            lo_q <= step_lo;
            cnt  <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mips_alu_seq.sv
// Sequential MIPS-style ALU with a valid/ready request and response side.
// Single-cycle ops are registered straight into the outputs; MULTU/DIVU take WIDTH extra steps.
module mips_alu_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op,
    output state_t           state_dbg
);

    // Handshake: a request is taken on the clk edge where in_valid && in_ready; a
    // response is consumed on the edge where out_valid && out_ready. Outputs hold until then.

    state_t           state;
    logic             accept;
    logic             calc_dbz;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_illegal;

    logic             iter_done;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

    always_comb begin
        add_sum     = {1'b0, opA} + {1'b0, opB};
        sub_diff    = {1'b0, opA} - {1'b0, opB};
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
                alu_ovf   = (opA[WIDTH-1] == opB[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != opA[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra difference bit is the unsigned borrow (opA < opB).
                alu_res   = sub_diff[WIDTH-1:0];
                alu_carry = sub_diff[WIDTH];
                alu_ovf   = (opA[WIDTH-1] != opB[WIDTH-1]) &&
                            (sub_diff[WIDTH-1] != opA[WIDTH-1]);
            end
            OP_SLL:   alu_res = opA << opB[SHW-1:0];
            OP_SRL:   alu_res = opA >> opB[SHW-1:0];
            OP_NOR:   alu_res = ~(opA | opB);
            OP_AND:   alu_res = opA & opB;
            OP_OR:    alu_res = opA | opB;
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (opA < opB)};
            OP_MULTU,
            OP_DIVU:  alu_res = '0;
            default:  alu_illegal = 1'b1;
        endcase
    end

    mips_muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && is_iterative(op)),
        .is_div (op == OP_DIVU),
        .a      (opA),
        .b      (opB),
        .done   (iter_done),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            calc_dbz    <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is registered so it stays low for the first cycle out of reset.
                    in_ready <= 1'b1;
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (is_iterative(op)) begin
                            state    <= CALC;
                            calc_dbz <= (op == OP_DIVU) && (opB == '0);
                        end else begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            result      <= alu_res;
                            result_hi   <= '0;
                            carry       <= alu_carry;
                            zero        <= (alu_res == '0);
                            overflow    <= alu_ovf;
                            div_by_zero <= 1'b0;
                            illegal_op  <= alu_illegal;
                        end
                    end
                end
                CALC: begin
                    // Capture on the step that brings the iteration counter to WIDTH.
                    if (iter_done) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        result      <= iter_lo;
                        result_hi   <= iter_hi;
                        carry       <= 1'b0;
                        zero        <= (iter_lo == '0);
                        overflow    <= 1'b0;
                        div_by_zero <= calc_dbz;
                        illegal_op  <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_seq.sv
// Directed bench for mips_alu_seq: hand-computed vectors, latency, backpressure and reset.
module tb_mips_alu_seq;
    import mips_alu_pkg::*;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [4:0]  fl;   // {carry, zero, overflow, div_by_zero, illegal_op}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        carry;
    logic        zero;
    logic        overflow;
    logic        div_by_zero;
    logic        illegal_op;
    state_t      state_dbg;

    int vectors = 0;
    int miscompares = 0;

    mips_alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .opA         (opA),
        .opB         (opB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .carry       (carry),
        .zero        (zero),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [68:0] observed();
        return {result_hi, result, carry, zero, overflow, div_by_zero, illegal_op};
    endfunction

    // ---------------- driver tasks ----------------
    // Issues one request, returns the number of cycles until out_valid is seen (capped at 100).
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        op       = o;
        opA      = a;
        opB      = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, observed()} !== 71'd0) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b outs=%h, want all 0",
                     in_ready, out_valid, observed());
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready: in_ready=%b before first edge, want 0", in_ready);
        end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || state_dbg !== IDLE) begin
            miscompares++;
            $display("FAIL reset_first_edge: in_ready=%b state=%0d, want 1/IDLE",
                     in_ready, state_dbg);
        end
    endtask

    task automatic test_single_cycle();
        vec_t tab[15];
        int   lat;
        tab[0]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000000, 5'b11000};
        tab[1]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h80000000, 5'b00100};
        tab[2]  = '{4'h1, 32'h00000003, 32'h00000005, 32'h0, 32'hFFFFFFFE, 5'b10000};
        tab[3]  = '{4'h1, 32'h80000000, 32'h00000001, 32'h0, 32'h7FFFFFFF, 5'b00100};
        tab[4]  = '{4'h1, 32'h00000005, 32'h00000005, 32'h0, 32'h00000000, 5'b01000};
        tab[5]  = '{4'h2, 32'h00000001, 32'h00000023, 32'h0, 32'h00000008, 5'b00000};
        tab[6]  = '{4'h7, 32'h80000000, 32'h0000003F, 32'h0, 32'h00000001, 5'b00000};
        tab[7]  = '{4'h3, 32'h0F0F0000, 32'h000000FF, 32'h0, 32'hF0F0FF00, 5'b00000};
        tab[8]  = '{4'h4, 32'h12345678, 32'h0F0F0F0F, 32'h0, 32'h02040608, 5'b00000};
        tab[9]  = '{4'h4, 32'h0000F0F0, 32'h00000F0F, 32'h0, 32'h00000000, 5'b01000};
        tab[10] = '{4'h6, 32'h00FF0000, 32'h000000F0, 32'h0, 32'h00FF00F0, 5'b00000};
        tab[11] = '{4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000001, 5'b00000};
        tab[12] = '{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000000, 5'b01000};
        tab[13] = '{4'hF, 32'h00000005, 32'h00000005, 32'h0, 32'h00000000, 5'b01001};
        tab[14] = '{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000000, 5'b01001};
        for (int i = 0; i < 15; i++) begin
            run_op(tab[i].op, tab[i].a, tab[i].b, lat);
            vectors++;
            if (observed() !== {tab[i].hi, tab[i].lo, tab[i].fl}) begin
                miscompares++;
                $display("FAIL single[%0d] op=%h: got hi=%h res=%h flags=%b, want hi=%h res=%h flags=%b",
                         i, tab[i].op, result_hi, result, observed()[4:0],
                         tab[i].hi, tab[i].lo, tab[i].fl);
            end
            vectors++;
            if (lat !== 1) begin
                miscompares++;
                $display("FAIL single_latency[%0d]: got %0d cycles, want 1", i, lat);
            end
            release_out();
        end
    endtask

    task automatic test_muldiv();
        vec_t tab[6];
        int   lat;
        tab[0] = '{4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5'b00000};
        tab[1] = '{4'h9, 32'h00003039, 32'h000003E8, 32'h00000000, 32'h00BC5EA8, 5'b00000};
        tab[2] = '{4'h9, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5'b01000};
        tab[3] = '{4'hA, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 5'b00000};
        tab[4] = '{4'hA, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 5'b00010};
        tab[5] = '{4'hA, 32'h00000007, 32'h00000064, 32'h00000007, 32'h00000000, 5'b01000};
        for (int i = 0; i < 6; i++) begin
            run_op(tab[i].op, tab[i].a, tab[i].b, lat);
            vectors++;
            if (observed() !== {tab[i].hi, tab[i].lo, tab[i].fl}) begin
                miscompares++;
                $display("FAIL muldiv[%0d] op=%h: got hi=%h res=%h flags=%b, want hi=%h res=%h flags=%b",
                         i, tab[i].op, result_hi, result, observed()[4:0],
                         tab[i].hi, tab[i].lo, tab[i].fl);
            end
            vectors++;
            if (lat !== 33) begin
                miscompares++;
                $display("FAIL muldiv_latency[%0d]: got %0d cycles, want 33", i, lat);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(4'h0, 32'd2, 32'd3, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op       = 4'h1;
            opA      = 32'd9;
            opB      = 32'd1;
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, 32'h0, 32'd5, 5'b00000}) begin
                miscompares++;
                $display("FAIL hold[%0d]: out_valid=%b in_ready=%b res=%h flags=%b, want 1 0 5 00000",
                         i, out_valid, in_ready, result, observed()[4:0]);
            end
        end
        in_valid = 1'b0;
        release_out();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_drop: out_valid=%b in_ready=%b after handshake, want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        op       = 4'h9;
        opA      = 32'hFFFFFFFF;
        opB      = 32'hFFFFFFFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, in_ready, observed()} !== 71'd0 || state_dbg !== IDLE) begin
            miscompares++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b outs=%h state=%0d, want all 0/IDLE",
                     out_valid, in_ready, observed(), state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'h2, 32'h1, 32'd35, lat);
        vectors++;
        if ({lat == 1, observed()} !== {1'b1, 32'h0, 32'h8, 5'b00000}) begin
            miscompares++;
            $display("FAIL sll_after_reset: lat=%0d res=%h flags=%b, want 1 8 00000",
                     lat, result, observed()[4:0]);
        end
        release_out();
        run_op(4'hF, 32'h1234, 32'h5678, lat);
        vectors++;
        if ({lat == 1, observed()} !== {1'b1, 32'h0, 32'h0, 5'b01001}) begin
            miscompares++;
            $display("FAIL illegal_after_reset: lat=%0d res=%h flags=%b, want 1 0 01001",
                     lat, result, observed()[4:0]);
        end
        release_out();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_alu_seq.md
MIPS_ALU_SEQ -- requirements
Module: mips_alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width (>=8, power of two).
REQ-002 SHALL have parameter: SHW, $clog2(WIDTH), shift-amount bits taken from opB.
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: in_valid  input  1  request valid.
REQ-006 SHALL have port: in_ready  output  1  block can accept a request.
REQ-007 SHALL have port: op  input  4  operation code (REQ-012).
REQ-008 SHALL have ports: opA, opB  input  WIDTH  operands.
REQ-009 SHALL have ports: out_valid output 1; out_ready input 1; result output WIDTH; result_hi output WIDTH (MULTU high / DIVU remainder).
REQ-010 SHALL have flag outputs, 1 bit each: carry, zero, overflow, div_by_zero, illegal_op.

Function
REQ-011 SHALL accept a request on the clk edge where in_valid && in_ready; opA, opB and op are captured on that edge.
REQ-012 SHALL decode op: 0000 ADD, 0001 SUB, 0010 SLL, 0011 NOR, 0100 AND, 0101 SLT (signed), 0110 OR, 0111 SRL, 1000 SLTU, 1001 MULTU, 1010 DIVU; 1011-1111 illegal.
REQ-013 SHALL use FSM states IDLE, CALC, DONE: IDLE->DONE for single-cycle ops; IDLE->CALC for MULTU/DIVU; CALC->DONE when the iteration counter reaches WIDTH; DONE->IDLE on out_ready.
REQ-014 SHALL drive in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-015 SHALL produce out_valid one cycle after acceptance for single-cycle and illegal ops, and WIDTH+1 cycles after acceptance for MULTU/DIVU.
REQ-016 SHALL hold result, result_hi and all flags stable while out_valid && !out_ready.
REQ-017 SHALL compute ADD as {carry,result} = opA+opB, with overflow = signed overflow.
REQ-018 SHALL compute SUB as result = opA-opB, carry = borrow (opA<opB unsigned), with overflow = signed overflow.
REQ-019 SHALL compute SLL/SRL as logical shifts by opB[SHW-1:0], upper opB bits ignored.
REQ-020 SHALL compute NOR as bitwise ~(opA|opB); AND and OR bitwise.
REQ-021 SHALL make SLT/SLTU result 1 or 0, zero-extended to WIDTH.
REQ-022 SHALL compute MULTU as unsigned shift-add, one bit per cycle, giving {result_hi,result} = 2*WIDTH-bit product.
REQ-023 SHALL compute DIVU as unsigned restoring division, one bit per cycle, giving result = quotient and result_hi = remainder.
REQ-024 SHALL, on DIVU with opB==0, return result = all ones, result_hi = opA and div_by_zero = 1, still taking WIDTH+1 cycles.
REQ-025 SHALL make zero = (result==0) for every op.
REQ-026 SHALL make result_hi = 0 for every op other than MULTU/DIVU.
REQ-027 SHALL make carry and overflow 0 except for ADD/SUB.
REQ-028 SHALL make an illegal op return result = 0 and illegal_op = 1, with zero = 1 and other flags 0.
REQ-029 SHALL ignore in_valid while not in IDLE; there are no queued requests.
REQ-030 SHALL use an iteration counter SHW+1 bits wide.

Reset
REQ-031 SHALL, on rst_n low at any time (including mid-CALC), immediately set state IDLE, counter 0, and result, result_hi and all flags 0.
REQ-032 SHALL, in reset, drive out_valid 0 and in_ready 0; in_ready goes 1 on the first clk edge after rst_n rises.

Structure
REQ-033 SHALL place the op encodings and FSM state encodings in shared package mips_alu_pkg.
REQ-034 SHALL implement MULTU/DIVU iteration in a single sub-module mips_muldiv_iter (start, op select, operands, done, hi/lo outputs).
REQ-035 SHALL keep single-cycle ops combinational, registered once into the output registers.

Verification (WIDTH=32)
REQ-036 SHALL cover: ADD 0xFFFFFFFF+0x00000001 -> result 0, carry 1, zero 1, overflow 0, out_valid 1 cycle after accept.
REQ-037 SHALL cover: ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow 1; SLT 0xFFFFFFFF,0x00000001 -> result 1; SLTU same operands -> result 0.
REQ-038 SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF -> result_hi 0xFFFFFFFE, result 0x00000001, out_valid exactly 33 cycles after accept.
REQ-039 SHALL cover: DIVU 100/7 -> result 14, result_hi 2; DIVU 5/0 -> result 0xFFFFFFFF, result_hi 5, div_by_zero 1.
REQ-040 SHALL cover: out_ready held low 5 cycles during DONE -> outputs stable, in_ready 0, new in_valid ignored.
REQ-041 SHALL cover: rst_n pulsed low at cycle 10 of MULTU -> out_valid 0 and outputs 0 immediately; a following SLL 1<<35 -> result 8; op 1111 -> illegal_op 1.
